// File: rtl/risc_toy_ex_stage.sv
// risc_toy_ex_stage: RISC_TOY execute stage (ALU, address generation, branch resolve) plus the EX/MEM register.
// Optional operand forwarding from XM/MW is enabled by defining RISC_TOY_EX_FWD_EN.
`default_nettype none

module risc_toy_ex_stage #(
    parameter int AW = 30,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          de_valid,
    input  logic [31:0]   de_instr,
    input  logic [AW-1:0] de_pc,
    input  logic [DW-1:0] de_rv1,
    input  logic [DW-1:0] de_rv2,
`ifdef RISC_TOY_EX_FWD_EN
    input  logic          mw_wer,
    input  logic [4:0]    mw_ra,
    input  logic [DW-1:0] mw_data,
`endif
    output logic          xm_valid,
    output logic [4:0]    xm_op,
    output logic [4:0]    xm_ra,
    output logic [31:0]   xm_instr,
    output logic [DW-1:0] xm_aluout,
    output logic [DW-1:0] xm_rv2,
    output logic          xm_we,
    output logic          xm_wer,
    output logic [AW-1:0] xm_pc4,
    output logic          br_taken,
    output logic [AW-1:0] br_target
);

    localparam logic [4:0] OP_ADDI = 5'd0;
    localparam logic [4:0] OP_ANDI = 5'd1;
    localparam logic [4:0] OP_ORI  = 5'd2;
    localparam logic [4:0] OP_MOVI = 5'd3;
    localparam logic [4:0] OP_ADD  = 5'd4;
    localparam logic [4:0] OP_SUB  = 5'd5;
    localparam logic [4:0] OP_NEG  = 5'd6;
    localparam logic [4:0] OP_NOT  = 5'd7;
    localparam logic [4:0] OP_AND  = 5'd8;
    localparam logic [4:0] OP_OR   = 5'd9;
    localparam logic [4:0] OP_XOR  = 5'd10;
    localparam logic [4:0] OP_LSR  = 5'd11;
    localparam logic [4:0] OP_ASR  = 5'd12;
    localparam logic [4:0] OP_SHL  = 5'd13;
    localparam logic [4:0] OP_ROR  = 5'd14;
    localparam logic [4:0] OP_BR   = 5'd15;
    localparam logic [4:0] OP_BRL  = 5'd16;
    localparam logic [4:0] OP_J    = 5'd17;
    localparam logic [4:0] OP_JL   = 5'd18;
    localparam logic [4:0] OP_LD   = 5'd19;
    localparam logic [4:0] OP_LDR  = 5'd20;
    localparam logic [4:0] OP_ST   = 5'd21;
    localparam logic [4:0] OP_STR  = 5'd22;

    logic [4:0]    op;
    logic [4:0]    ra_f;
    logic [4:0]    rb_f;
    logic [DW-1:0] rb_val;
    logic [DW-1:0] rv2_val;
    logic [DW-1:0] imm17_s;
    logic [DW-1:0] imm17_z;
    logic [DW-1:0] imm22_s;
    logic [AW-1:0] j_off;
    logic [AW-1:0] pc4;
    logic [DW-1:0] pc4_byte;
    logic [DW-1:0] ld_base;
    logic [4:0]    amt;
    logic [2*DW-1:0] ror_wide;
    logic          cond_ok;

    logic [DW-1:0] alu;
    logic          we;
    logic          wer;
    logic          taken;
    logic [AW-1:0] target;

    assign op   = de_instr[31:27];
    assign ra_f = de_instr[26:22];
    assign rb_f = de_instr[21:17];

`ifdef RISC_TOY_EX_FWD_EN
    logic [4:0] rc_f;
    logic [4:0] rv2_f;
    logic       xm_fwd_ok;

    assign rc_f = de_instr[16:12];
    // The second operand names ra for stores and BR/BRL (data / condition), rc otherwise.
    assign rv2_f = (op == OP_ST || op == OP_STR || op == OP_BR || op == OP_BRL) ? ra_f : rc_f;
    // A load in XM has no data yet; its XM_ALUOUT is an address.
    assign xm_fwd_ok = xm_wer && (xm_op != OP_LD) && (xm_op != OP_LDR);

    always_comb begin
        rb_val = de_rv1;
        if (xm_fwd_ok && xm_ra == rb_f)
            rb_val = xm_aluout;
        else if (mw_wer && mw_ra == rb_f && rb_f != 5'd0)
            rb_val = mw_data;

        rv2_val = de_rv2;
        if (xm_fwd_ok && xm_ra == rv2_f)
            rv2_val = xm_aluout;
        else if (mw_wer && mw_ra == rv2_f && rv2_f != 5'd0)
            rv2_val = mw_data;
    end
`else
    assign rb_val  = de_rv1;
    assign rv2_val = de_rv2;
`endif

    assign imm17_s  = {{(DW-17){de_instr[16]}}, de_instr[16:0]};
    assign imm17_z  = {{(DW-17){1'b0}}, de_instr[16:0]};
    assign imm22_s  = {{(DW-22){de_instr[21]}}, de_instr[21:0]};
    assign j_off    = {{(AW-22){de_instr[21]}}, de_instr[21:0]};
    assign pc4      = de_pc + AW'(1);
    assign pc4_byte = DW'({pc4, 2'b00});
    assign ld_base  = (rb_f == 5'd31) ? '0 : rb_val;
    assign amt      = de_instr[4] ? rv2_val[4:0] : de_instr[4:0];
    assign ror_wide = {rb_val, rb_val} >> amt;

    always_comb begin
        case (de_instr[2:0])
            3'd1:    cond_ok = 1'b1;
            3'd2:    cond_ok = (rv2_val == '0);
            3'd3:    cond_ok = (rv2_val != '0);
            3'd4:    cond_ok = ~rv2_val[DW-1];
            3'd5:    cond_ok = rv2_val[DW-1];
            default: cond_ok = 1'b0;
        endcase
    end

    always_comb begin
        alu    = '0;
        we     = 1'b0;
        wer    = 1'b0;
        taken  = 1'b0;
        target = '0;
        case (op)
            OP_ADDI: begin alu = rb_val + imm17_s;              wer = 1'b1; end
            OP_ANDI: begin alu = rb_val & imm17_z;              wer = 1'b1; end
            OP_ORI:  begin alu = rb_val | imm17_z;              wer = 1'b1; end
            OP_MOVI: begin alu = imm17_s;                       wer = 1'b1; end
            OP_ADD:  begin alu = rb_val + rv2_val;              wer = 1'b1; end
            OP_SUB:  begin alu = rb_val - rv2_val;              wer = 1'b1; end
            OP_NEG:  begin alu = -rv2_val;                      wer = 1'b1; end
            OP_NOT:  begin alu = ~rv2_val;                      wer = 1'b1; end
            OP_AND:  begin alu = rb_val & rv2_val;              wer = 1'b1; end
            OP_OR:   begin alu = rb_val | rv2_val;              wer = 1'b1; end
            OP_XOR:  begin alu = rb_val ^ rv2_val;              wer = 1'b1; end
            OP_LSR:  begin alu = rb_val >> amt;                 wer = 1'b1; end
            OP_ASR:  begin alu = $unsigned($signed(rb_val) >>> amt); wer = 1'b1; end
            OP_SHL:  begin alu = rb_val << amt;                 wer = 1'b1; end
            OP_ROR:  begin alu = ror_wide[DW-1:0];              wer = 1'b1; end
            OP_BR, OP_BRL: begin
                target = rb_val[AW+1:2];
                taken  = cond_ok;
                wer    = (op == OP_BRL);
            end
            OP_J, OP_JL: begin
                target = pc4 + j_off;
                taken  = 1'b1;
                wer    = (op == OP_JL);
            end
            OP_LD:   begin alu = ld_base + imm17_s;             wer = 1'b1; end
            OP_LDR:  begin alu = pc4_byte + imm22_s;            wer = 1'b1; end
            OP_ST:   begin alu = ld_base + imm17_s;             we  = 1'b1; end
            OP_STR:  begin alu = pc4_byte + imm22_s;            we  = 1'b1; end
            default: ;
        endcase
    end

    // Flush beats stall; an empty DE slot loads a bubble only when not stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush || (!stall && !de_valid)) begin
            xm_valid  <= 1'b0;
            xm_op     <= '0;
            xm_ra     <= '0;
            xm_instr  <= '0;
            xm_aluout <= '0;
            xm_rv2    <= '0;
            xm_we     <= 1'b0;
            xm_wer    <= 1'b0;
            xm_pc4    <= '0;
            br_taken  <= 1'b0;
            br_target <= '0;
        end else if (stall) begin
            br_taken  <= 1'b0;
        end else begin
            xm_valid  <= 1'b1;
            xm_op     <= op;
            xm_ra     <= ra_f;
            xm_instr  <= de_instr;
            xm_aluout <= alu;
            xm_rv2    <= rv2_val;
            xm_we     <= we;
            xm_wer    <= wer;
            xm_pc4    <= pc4;
            br_taken  <= taken;
            br_target <= target;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_risc_toy_ex_stage.sv
// Scoreboard bench for risc_toy_ex_stage: the driver queues hand-computed expectations, a monitor checks each cycle.
`default_nettype none

module tb_risc_toy_ex_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, de_valid;
    logic [31:0] de_instr;
    logic [29:0] de_pc;
    logic [31:0] de_rv1, de_rv2;
    logic        xm_valid, xm_we, xm_wer, br_taken;
    logic [4:0]  xm_op, xm_ra;
    logic [31:0] xm_instr, xm_aluout, xm_rv2;
    logic [29:0] xm_pc4, br_target;
`ifdef RISC_TOY_EX_FWD_EN
    logic        mw_wer = 1'b0;
    logic [4:0]  mw_ra = '0;
    logic [31:0] mw_data = '0;
`endif
    logic        nx_mw_wer = 1'b0;
    logic [4:0]  nx_mw_ra = '0;
    logic [31:0] nx_mw_data = '0;

    risc_toy_ex_stage #(.AW(30), .DW(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .de_valid(de_valid), .de_instr(de_instr), .de_pc(de_pc),
        .de_rv1(de_rv1), .de_rv2(de_rv2),
`ifdef RISC_TOY_EX_FWD_EN
        .mw_wer(mw_wer), .mw_ra(mw_ra), .mw_data(mw_data),
`endif
        .xm_valid(xm_valid), .xm_op(xm_op), .xm_ra(xm_ra), .xm_instr(xm_instr),
        .xm_aluout(xm_aluout), .xm_rv2(xm_rv2), .xm_we(xm_we), .xm_wer(xm_wer),
        .xm_pc4(xm_pc4), .br_taken(br_taken), .br_target(br_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        valid;
        logic [4:0]  op, ra;
        logic [31:0] instr, alu, rv2;
        logic        we, wer, bt;
        logic [29:0] pc4, tgt;
        logic        chk_alu, chk_rv2, chk_tgt;
    } exp_t;

    exp_t q[$];
    exp_t last;
    exp_t mon;
    int   total = 0;
    int   bad = 0;

    function automatic exp_t zexp(input string nm);
        exp_t e;
        e.name = nm; e.valid = 0; e.op = 0; e.ra = 0; e.instr = 0; e.alu = 0; e.rv2 = 0;
        e.we = 0; e.wer = 0; e.bt = 0; e.pc4 = 0; e.tgt = 0;
        e.chk_alu = 1; e.chk_rv2 = 1; e.chk_tgt = 1;
        return e;
    endfunction

    function automatic logic [31:0] rr(input logic [4:0] op, ra, rb, rc, input logic [11:0] lo);
        return {op, ra, rb, rc, lo};
    endfunction
    function automatic logic [31:0] ii(input logic [4:0] op, ra, rb, input logic [16:0] imm);
        return {op, ra, rb, imm};
    endfunction
    function automatic logic [31:0] jj(input logic [4:0] op, ra, input logic [21:0] imm);
        return {op, ra, imm};
    endfunction

    task automatic apply_mw();
`ifdef RISC_TOY_EX_FWD_EN
        mw_wer = nx_mw_wer; mw_ra = nx_mw_ra; mw_data = nx_mw_data;
`endif
    endtask

    // Valid instruction: alu/rv2/target are checked only where they carry meaning for that opcode.
    task automatic issue(input string nm, input logic [31:0] ins, input logic [29:0] pc,
                         input logic [31:0] a, b, ealu, input logic cka,
                         input logic ewe, ewer, ebt, input logic [29:0] etgt);
        exp_t e;
        @(negedge clk);
        rst = 0; stall = 0; flush = 0; de_valid = 1;
        de_instr = ins; de_pc = pc; de_rv1 = a; de_rv2 = b;
        apply_mw();
        e = zexp(nm);
        e.valid = 1; e.op = ins[31:27]; e.ra = ins[26:22]; e.instr = ins;
        e.alu = ealu; e.chk_alu = cka; e.rv2 = b; e.chk_rv2 = ewe;
        e.we = ewe; e.wer = ewer; e.pc4 = pc + 30'd1; e.bt = ebt; e.tgt = etgt; e.chk_tgt = ebt;
        q.push_back(e); last = e;
    endtask

    task automatic bubble(input string nm, input logic st, fl, v);
        exp_t e;
        @(negedge clk);
        rst = 0; stall = st; flush = fl; de_valid = v;
        de_instr = rr(5'd4, 5'd1, 5'd2, 5'd3, 12'h0); de_rv1 = 32'h11; de_rv2 = 32'h22;
        e = zexp(nm);
        q.push_back(e); last = e;
    endtask

    task automatic stall_cycle(input string nm);
        exp_t e;
        @(negedge clk);
        rst = 0; stall = 1; flush = 0; de_valid = 1;
        de_instr = rr(5'd4, 5'd7, 5'd7, 5'd7, 12'h0); de_rv1 = 32'h5; de_rv2 = 32'h6;
        e = last; e.name = nm; e.bt = 0;
        q.push_back(e); last = e;
    endtask

    task automatic reset_cycle(input string nm);
        exp_t e;
        @(negedge clk);
        rst = 1; stall = 0; flush = 0; de_valid = 1;
        de_instr = rr(5'd4, 5'd1, 5'd2, 5'd3, 12'h0); de_rv1 = 32'h7; de_rv2 = 32'h8;
        e = zexp(nm);
        q.push_back(e); last = e;
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            mon = q.pop_front();
            total++;
            if (xm_valid !== mon.valid || xm_op !== mon.op || xm_ra !== mon.ra ||
                xm_instr !== mon.instr || xm_we !== mon.we || xm_wer !== mon.wer ||
                xm_pc4 !== mon.pc4 || br_taken !== mon.bt ||
                (mon.chk_alu && xm_aluout !== mon.alu) ||
                (mon.chk_rv2 && xm_rv2 !== mon.rv2) ||
                (mon.chk_tgt && br_target !== mon.tgt)) begin
                bad++;
                $display("FAIL %s: got v=%b op=%0d ra=%0d ins=%h alu=%h rv2=%h we=%b wer=%b pc4=%h bt=%b tgt=%h | want v=%b op=%0d ra=%0d ins=%h alu=%h rv2=%h we=%b wer=%b pc4=%h bt=%b tgt=%h",
                         mon.name, xm_valid, xm_op, xm_ra, xm_instr, xm_aluout, xm_rv2, xm_we, xm_wer,
                         xm_pc4, br_taken, br_target, mon.valid, mon.op, mon.ra, mon.instr, mon.alu,
                         mon.rv2, mon.we, mon.wer, mon.pc4, mon.bt, mon.tgt);
            end
        end
    end

    initial begin
        rst = 1; stall = 0; flush = 0; de_valid = 0;
        de_instr = '0; de_pc = '0; de_rv1 = '0; de_rv2 = '0;
        last = zexp("init");

        reset_cycle("reset0");
        reset_cycle("reset1");

        // Arithmetic and logic
        issue("add_wrap", rr(4, 1, 2, 3, 0),       30'h10, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1, 0, 1, 0, 0);
        issue("asr_imm4", rr(12, 1, 2, 0, 12'h004), 30'h11, 32'h80000000, 32'h0, 32'hF8000000, 1, 0, 1, 0, 0);
        issue("ror_imm1", rr(14, 1, 2, 0, 12'h001), 30'h12, 32'h1,        32'h0, 32'h80000000, 1, 0, 1, 0, 0);
        issue("lsr_amt0", rr(11, 1, 2, 0, 12'h000), 30'h13, 32'h12345678, 32'h0, 32'h12345678, 1, 0, 1, 0, 0);
        issue("shl_reg",  rr(13, 1, 2, 3, 12'h010), 30'h14, 32'h1,        32'h3, 32'h8,        1, 0, 1, 0, 0);
        issue("sub",      rr(5, 1, 2, 3, 0),       30'h15, 32'd10,       32'd3, 32'd7,        1, 0, 1, 0, 0);
        issue("neg",      rr(6, 1, 2, 3, 0),       30'h16, 32'h0,        32'd5, 32'hFFFFFFFB, 1, 0, 1, 0, 0);
        issue("not",      rr(7, 1, 2, 3, 0),       30'h17, 32'h0,        32'h0, 32'hFFFFFFFF, 1, 0, 1, 0, 0);
        issue("and",      rr(8, 1, 2, 3, 0),       30'h18, 32'hF0F0,     32'hFF00, 32'hF000,   1, 0, 1, 0, 0);
        issue("or",       rr(9, 1, 2, 3, 0),       30'h19, 32'hF0F0,     32'hFF00, 32'hFFF0,   1, 0, 1, 0, 0);
        issue("xor",      rr(10, 1, 2, 3, 0),      30'h1A, 32'hF0F0,     32'hFF00, 32'h0FF0,   1, 0, 1, 0, 0);
        issue("addi_neg", ii(0, 1, 2, 17'h1FFFF),  30'h1B, 32'd10,       32'h0, 32'd9,        1, 0, 1, 0, 0);
        issue("andi_zx",  ii(1, 1, 2, 17'h1FFFF),  30'h1C, 32'hFFFFFFFF, 32'h0, 32'h0001FFFF, 1, 0, 1, 0, 0);
        issue("ori_zx",   ii(2, 1, 2, 17'h10000),  30'h1D, 32'h0,        32'h0, 32'h00010000, 1, 0, 1, 0, 0);
        issue("movi_sx",  ii(3, 1, 2, 17'h10000),  30'h1E, 32'h0,        32'h0, 32'hFFFF0000, 1, 0, 1, 0, 0);

        // Memory
        issue("st",       ii(21, 1, 2, 17'h1FFFC), 30'h20, 32'h100, 32'hAB, 32'hFC,  1, 1, 0, 0, 0);
        issue("ld_r31",   ii(19, 1, 31, 17'h8),    30'h21, 32'h500, 32'h0,  32'h8,   1, 0, 1, 0, 0);
        issue("ld",       ii(19, 1, 2, 17'h8),     30'h22, 32'h500, 32'h0,  32'h508, 1, 0, 1, 0, 0);
        issue("ldr",      jj(20, 1, 22'h4),        30'h10, 32'h0,   32'h0,  32'h48,  1, 0, 1, 0, 0);
        issue("str",      jj(22, 1, 22'h3FFFFC),   30'h10, 32'h0,   32'h55, 32'h40,  1, 1, 0, 0, 0);

        // Branches: taken pulse then held stall
        issue("brl_eq0",  rr(16, 1, 3, 0, 12'h002), 30'h10, 32'h400, 32'h0, 0, 0, 0, 1, 1, 30'h100);
        stall_cycle("brl_stall1");
        stall_cycle("brl_stall2");
        stall_cycle("brl_stall3");
        issue("after_br", rr(4, 1, 2, 3, 0),        30'h30, 32'd1, 32'd2, 32'd3, 1, 0, 1, 0, 0);
        issue("br_ne0_nt", rr(15, 1, 3, 0, 12'h003), 30'h31, 32'h800, 32'h0,        0, 0, 0, 0, 0, 0);
        issue("br_lt0",    rr(15, 1, 3, 0, 12'h005), 30'h32, 32'h800, 32'h80000000, 0, 0, 0, 0, 1, 30'h200);
        issue("br_lt0_b2b", rr(15, 1, 3, 0, 12'h005), 30'h33, 32'hC, 32'h80000000,  0, 0, 0, 0, 1, 30'h3);
        issue("br_ge0_nt", rr(15, 1, 3, 0, 12'h004), 30'h34, 32'h800, 32'h80000000, 0, 0, 0, 0, 0, 0);
        issue("br_never",  rr(15, 1, 3, 0, 12'h000), 30'h35, 32'h800, 32'h0,        0, 0, 0, 0, 0, 0);
        issue("br_c6",     rr(15, 1, 3, 0, 12'h006), 30'h36, 32'h800, 32'h0,        0, 0, 0, 0, 0, 0);
        issue("br_always", rr(15, 1, 3, 0, 12'h001), 30'h37, 32'hC,   32'h1,        0, 0, 0, 0, 1, 30'h3);
        issue("j_back",   jj(17, 0, 22'h3FFFFE),    30'h20, 32'h0, 32'h0, 0, 0, 0, 0, 1, 30'h1F);
        issue("jl_fwd",   jj(18, 5, 22'h10),        30'h20, 32'h0, 32'h0, 0, 0, 0, 1, 1, 30'h31);
        issue("unknown",  rr(25, 1, 2, 3, 0),       30'h40, 32'h1, 32'h2, 0, 0, 0, 0, 0, 0);

        // Bubbles and priority
        bubble("flush_stall", 1, 1, 1);
        issue("reload",   rr(4, 2, 2, 3, 0), 30'h41, 32'd4, 32'd5, 32'd9, 1, 0, 1, 0, 0);
        bubble("flush", 0, 1, 1);
        bubble("de_invalid", 0, 0, 0);
        stall_cycle("stall_bubble");

        // Reset mid-run discards the instruction in flight
        issue("pre_rst",  rr(4, 3, 2, 3, 0), 30'h50, 32'd1, 32'd1, 32'd2, 1, 0, 1, 0, 0);
        reset_cycle("rst_mid0");
        reset_cycle("rst_mid1");
        issue("post_rst", rr(4, 3, 2, 3, 0), 30'h51, 32'd6, 32'd1, 32'd7, 1, 0, 1, 0, 0);

`ifdef RISC_TOY_EX_FWD_EN
        issue("fwd_src",  rr(4, 1, 2, 3, 0), 30'h60, 32'd5, 32'd6, 32'd11, 1, 0, 1, 0, 0);
        issue("fwd_xm",   rr(4, 2, 1, 1, 0), 30'h61, 32'd0, 32'd0, 32'd22, 1, 0, 1, 0, 0);
        nx_mw_wer = 1; nx_mw_ra = 5'd3; nx_mw_data = 32'd100;
        issue("fwd_mw",   rr(4, 4, 3, 0, 0), 30'h62, 32'd0, 32'd7, 32'd107, 1, 0, 1, 0, 0);
        nx_mw_wer = 0; nx_mw_ra = 5'd0; nx_mw_data = 32'd0;
        issue("ld_nofwd", ii(19, 5, 31, 17'h40), 30'h63, 32'h0, 32'h0, 32'h40, 1, 0, 1, 0, 0);
        issue("after_ld", rr(4, 6, 5, 0, 0), 30'h64, 32'd1, 32'd2, 32'd3, 1, 0, 1, 0, 0);
`endif

        @(negedge clk);
        de_valid = 0;
        repeat (3) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
